// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: receive and transmit state encodings plus default
// frame constants used by both halves of the UART.
package uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_STOP_BITS    = 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Transmit states carry a TX_ prefix so they coexist with the receiver's names.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int stop_bits);
        return (1 + data_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Free-running bit-period timer for the transmitter: counts 0..CLKS_PER_BIT-1
// and strobes bit_end on the last cycle of every bit period.
module uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // bit_pre_end lets registered outputs line up with the final cycle of a bit.
    assign bit_end     = (count == LAST);
    assign bit_pre_end = (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes a byte over valid/ready and serialises it as
// start bit, LSB-first data bits and STOP_BITS stop bits on tx.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output tx_state_t            dbg_state
);

    // Handshake: a byte is taken on any rising edge where valid && ready; ready
    // never depends on valid, and valid without ready is ignored.

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [IW-1:0]        bit_idx;
    logic                 stop_cnt;
    logic                 bit_end;
    logic                 bit_pre_end;
    logic                 last_stop;
    logic                 accept;

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == TX_IDLE),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    // The final stop cycle also accepts, so frames can run back to back.
    assign ready     = (state == TX_IDLE) || ((state == TX_STOP) && last_stop && bit_end);
    assign accept    = valid && ready;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == TX_STOP) && last_stop && bit_pre_end;
            case (state)
                TX_IDLE: begin
                    if (accept) begin
                        shift <= data;
                        state <= TX_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            state    <= TX_STOP;
                            stop_cnt <= 1'b0;
                            tx       <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + IW'(1);
                            tx      <= shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else if (accept) begin
                            shift <= data;
                            state <= TX_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two configurations driven from shared stimulus and checked
// every cycle against a frame-position model, plus directed literal checks.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int C1 = 16;
    localparam int D1 = 8;
    localparam int S1 = 1;
    localparam int F1 = (1 + D1 + S1) * C1;
    localparam int C2 = 4;
    localparam int D2 = 7;
    localparam int S2 = 2;
    localparam int F2 = (1 + D2 + S2) * C2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;

    logic      ready1, tx1, busy1, done1;
    logic      ready2, tx2, busy2, done2;
    tx_state_t st1, st2;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C1), .DATA_BITS(D1), .STOP_BITS(S1)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready1),
        .tx(tx1), .busy(busy1), .done(done1), .dbg_state(st1)
    );

    uart_tx #(.CLKS_PER_BIT(C2), .DATA_BITS(D2), .STOP_BITS(S2)) u_dut2 (
        .clk(clk), .rst(rst), .data(data[6:0]), .valid(valid), .ready(ready2),
        .tx(tx2), .busy(busy2), .done(done2), .dbg_state(st2)
    );

    // Model: rem = cycles left in the current frame (0 = idle); the line level
    // follows from how far into the frame we are.
    typedef struct packed {
        int         rem;
        logic [7:0] b;
    } mdl_t;

    mdl_t m1 = '0;
    mdl_t m2 = '0;

    function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic v,
                                      input logic [7:0] d, input int f);
        mdl_t n = m;
        if (r) begin
            n.rem = 0;
        end else if (v && m.rem <= 1) begin
            n.rem = f;
            n.b   = d;
        end else if (m.rem > 0) begin
            n.rem = m.rem - 1;
        end
        return n;
    endfunction

    function automatic logic mdl_tx(input mdl_t m, input int c, input int d, input int f);
        int k;
        if (m.rem == 0) return 1'b1;
        k = (f - m.rem) / c;
        if (k == 0) return 1'b0;
        if (k <= d) return m.b[k-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m1 = mdl_step(m1, rst, valid, data, F1);
        m2 = mdl_step(m2, rst, valid, data & 8'h7f, F2);
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("tx1",    32'(tx1),    32'(mdl_tx(m1, C1, D1, F1)));
            chk("ready1", 32'(ready1), 32'(m1.rem <= 1));
            chk("busy1",  32'(busy1),  32'(m1.rem > 0));
            chk("done1",  32'(done1),  32'(m1.rem == 1));
            chk("tx2",    32'(tx2),    32'(mdl_tx(m2, C2, D2, F2)));
            chk("ready2", 32'(ready2), 32'(m2.rem <= 1));
            chk("busy2",  32'(busy2),  32'(m2.rem > 0));
            chk("done2",  32'(done2),  32'(m2.rem == 1));
        end
    end

    task automatic wait_both_ready();
        int t = 0;
        while (!(ready1 && ready2) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready1=%0b ready2=%0b expected 1 1", ready1, ready2);
        end
    endtask

    task automatic send_one(input logic [7:0] b);
        wait_both_ready();
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        logic [0:9] a5_exp = 10'b0101001011;
        int done_n, done_at, cnt, rdy_n;

        // Reset held with valid high: nothing may start.
        data  = 8'($urandom);
        rst   = 1'b1;
        valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx",    32'(tx1),    32'd1);
            chk("rst_ready", 32'(ready1), 32'd1);
            chk("rst_busy",  32'(busy1),  32'd0);
        end
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy1), 32'd0);

        // 0xA5 with data toggling mid-frame.
        send_one(8'hA5);
        done_n  = 0;
        done_at = -1;
        for (int j = 0; j < 170; j++) begin
            if (j < 160 && (j % 16) == 8) chk("a5_bit", 32'(tx1), 32'(a5_exp[j/16]));
            if (done1) begin
                done_n++;
                done_at = j;
            end
            data = 8'($urandom);
            @(negedge clk);
        end
        chk("a5_done_n",  32'(done_n),  32'd1);
        chk("a5_done_at", 32'(done_at), 32'd159);

        // 7 data bits, 2 stop bits: 40-cycle frame ending in 8 high cycles.
        send_one(8'h55);
        cnt = 0;
        done_n = 0;
        for (int j = 0; j < 60; j++) begin
            if (busy2) cnt++;
            if (j >= 32 && j < 40 && tx2) done_n++;
            @(negedge clk);
        end
        chk("s2_busy_len", 32'(cnt),    32'd40);
        chk("s2_stop_hi",  32'(done_n), 32'd8);

        // Back-to-back frames with valid held high.
        wait_both_ready();
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        data  = 8'hC3;
        rdy_n = 0;
        for (int j = 0; j < 330; j++) begin
            if (j == 160) begin
                valid = 1'b0;
                chk("b2b_start", 32'(tx1), 32'd0);
            end
            if (j < 319 && ready1) rdy_n++;
            if (j == 319) chk("b2b_busy_end", 32'(busy1), 32'd1);
            if (j == 320) chk("b2b_idle", 32'(busy1), 32'd0);
            @(negedge clk);
        end
        chk("b2b_ready_n", 32'(rdy_n), 32'd1);

        // Reset in the middle of data bit 3 of 0xFF.
        send_one(8'hFF);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx",   32'(tx1),   32'd1);
        chk("midrst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        done_n = 0;
        for (int j = 0; j < 200; j++) begin
            if (done1) done_n++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(done_n), 32'd0);
        send_one(8'h00);
        cnt = 0;
        for (int j = 0; j < 170; j++) begin
            if (!tx1) cnt++;
            @(negedge clk);
        end
        chk("zero_low_cycles", 32'(cnt), 32'd144);

        // Idle with valid low: line stays high.
        cnt = 0;
        for (int j = 0; j < 50; j++) begin
            if (tx1) cnt++;
            data = 8'($urandom);
            @(negedge clk);
        end
        chk("idle_high", 32'(cnt), 32'd50);

        // Randomised traffic with occasional resets.
        for (int j = 0; j < 4000; j++) begin
            rst   = ($urandom_range(0, 599) == 0);
            valid = ($urandom_range(0, 7) == 0);
            data  = 8'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        valid = 1'b0;
        wait_both_ready();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
